piso_seq_ctrl: RTL and testbench

- Sequencer for the PMU 128-bit parallel-in/serial-out datapath.
- Accepts 128-bit blocks from the upstream crypto/bitstream path on a valid/ready handshake, buffers one block, and drives the shifter's load/enable.
- Emits one bit per accepted beat to the serial sink on a valid/ready handshake.
- Gives zero-bubble back-to-back streaming: the next block loads on the cycle the last bit of the current block is accepted.

---
 rtl/piso_seq_pkg.sv | 16 +
 rtl/piso_seq_ctrl_piso.sv | 30 +++
 rtl/piso_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_piso_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_seq_pkg.sv
// Shared types and helpers for the PISO sequencer: FSM state encoding,
// default block width and a counter width that never collapses to zero.
package piso_seq_pkg;

    localparam int DATA_W_DEF = 128;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_seq_ctrl_piso.sv
// PISO datapath: parallel load has priority over shift; shifts left with zero
// fill and presents the MSB as the serial output.
module piso_seq_ctrl_piso
    import piso_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] data_i,
    output logic              data_o
);

    logic [DATA_W-1:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (load) begin
            r_shift <= data_i;
        end else if (en) begin
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign data_o = r_shift[DATA_W-1];

endmodule

// File: rtl/piso_seq_ctrl.sv
// Sequencer for the 128-bit PISO path: one-block holding buffer, bit counter and
// valid/ready handshakes on both sides with zero-bubble block chaining.
module piso_seq_ctrl
    import piso_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    input  logic [DATA_W-1:0] blk_data_i,
    input  logic              abort_i,
    output logic              bit_o,
    output logic              bit_valid_o,
    input  logic              bit_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  bit_idx_o
);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_buf;

    logic              w_blk_acc;
    logic              w_bit_acc;
    logic              w_last;
    logic              w_load;
    logic              w_en;
    logic [DATA_W-1:0] w_load_data;
    logic              w_shift_bit;

    assign w_blk_acc = blk_valid_i & ~r_buf_full & ~abort_i;
    assign w_bit_acc = (r_state == SHIFT) & bit_ready_i & ~abort_i;
    assign w_last    = w_bit_acc & (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort_i) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_blk_acc) w_next = SHIFT;
                SHIFT:   if (w_last && !r_buf_full && !w_blk_acc) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Abort reuses the parallel load with an all-zero word to clear the shifter.
    always_comb begin
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_load_data = blk_data_i;
        if (abort_i) begin
            w_load      = 1'b1;
            w_load_data = '0;
        end else if (r_state == IDLE) begin
            w_load = w_blk_acc;
        end else if (w_last && (r_buf_full || w_blk_acc)) begin
            w_load = 1'b1;
            if (r_buf_full) w_load_data = r_buf;
        end else begin
            w_en = w_bit_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_buf_full <= 1'b0;
            r_buf      <= '0;
        end else if (abort_i) begin
            r_cnt      <= '0;
            r_buf_full <= 1'b0;
        end else begin
            if (w_load || w_last) begin
                r_cnt <= '0;
            end else if (w_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A block arriving on the last bit with an empty buffer bypasses it.
            if (w_last && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (w_blk_acc && (r_state == SHIFT) && !w_last) begin
                r_buf      <= blk_data_i;
                r_buf_full <= 1'b1;
            end
        end
    end

    piso_seq_ctrl_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .en     (w_en),
        .data_i (w_load_data),
        .data_o (w_shift_bit)
    );

    assign bit_o       = w_shift_bit;
    assign bit_valid_o = (r_state == SHIFT);
    assign done_o      = w_last;
    assign bit_idx_o   = r_cnt;
    assign blk_ready_o = ~r_buf_full;
    assign busy_o      = (r_state == SHIFT) | r_buf_full;

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Scoreboard bench for piso_seq_ctrl: accepted blocks push their expected bits,
// a negedge monitor pops and compares every accepted serial bit.
module tb_piso_seq_ctrl;

    localparam int DW = 128;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          blk_valid_i = 1'b0;
    logic          blk_ready_o;
    logic [DW-1:0] blk_data_i = '0;
    logic          abort_i = 1'b0;
    logic          bit_o;
    logic          bit_valid_o;
    logic          bit_ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] bit_idx_o;

    piso_seq_ctrl #(
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid_i (blk_valid_i),
        .blk_ready_o (blk_ready_o),
        .blk_data_i  (blk_data_i),
        .abort_i     (abort_i),
        .bit_o       (bit_o),
        .bit_valid_o (bit_valid_o),
        .bit_ready_i (bit_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bit_idx_o   (bit_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   idx;
    } exp_t;

    exp_t          q[$];
    int            done_cyc[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic          stall_v = 1'b0;
    logic          stall_b = 1'b0;
    logic [CW-1:0] stall_i = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change only just after posedge, so negedge sees what the next edge will sample.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("stall_hold_bit", bit_o, stall_b);
                check("stall_hold_idx", bit_idx_o, stall_i);
            end
            if (q.size() != 0 && !abort_i) check("no_gap_valid", bit_valid_o, 1);
            if (done_o) done_cyc.push_back(cyc);
            if (bit_valid_o && bit_ready_i && !abort_i) begin
                if (q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("bit_o", bit_o, e.b);
                    check("bit_idx_o", bit_idx_o, e.idx);
                    check("done_o", done_o, (e.idx == DW - 1));
                end
            end else begin
                check("done_idle", done_o, 0);
            end
            stall_v = bit_valid_o && !bit_ready_i && !abort_i;
            stall_b = bit_o;
            stall_i = bit_idx_o;
        end
    end

    // Call just after a posedge; returns just after the accepting posedge.
    task automatic send_block(input logic [DW-1:0] d);
        blk_data_i  = d;
        blk_valid_i = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (blk_ready_o && !abort_i) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < DW; i++) q.push_back(exp_t'{b: d[DW-1-i], idx: i});
                blk_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        blk_valid_i = 1'b0;
        check("blk_accept_timeout", 0, 1);
    endtask

    task automatic wait_idx(input int k);
        for (int t = 0; t < 600; t++) begin
            if (bit_valid_o && bit_idx_o == CW'(k)) return;
            @(posedge clk);
            #1;
        end
        check("wait_idx_timeout", 0, 1);
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 700; t++) begin
            if (q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        check("wait_empty_timeout", q.size(), 0);
    endtask

    localparam logic [DW-1:0] BLK_A = 128'habcdef0123456789abcdef0123456789;
    localparam logic [DW-1:0] BLK_B = 128'h9876543210fedcba9876543210fedcba;
    localparam logic [DW-1:0] BLK_C = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [DW-1:0] BLK_D = 128'hf00dcafe_12345678_deadbeef_a5a55a5a;
    localparam logic [DW-1:0] BLK_E = 128'h55555555_aaaaaaaa_33333333_cccccccc;
    localparam logic [DW-1:0] BLK_F = 128'hffffffff_00000000_ffffffff_00000000;
    localparam logic [DW-1:0] BLK_G = 128'h80000000_00000000_00000000_00000001;

    initial begin
        int n;
        #1;
        check("rst_bit_valid", bit_valid_o, 0);
        check("rst_blk_ready", blk_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_bit_o", bit_o, 0);
        check("rst_bit_idx", bit_idx_o, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bit_ready_i = 1'b1;

        // Single block
        done_cyc.delete();
        send_block(BLK_A);
        check("single_first_valid", bit_valid_o, 1);
        check("single_first_bit", bit_o, 1);
        wait_empty();
        check("single_idle_valid", bit_valid_o, 0);
        check("single_idle_busy", busy_o, 0);
        check("single_idle_ready", blk_ready_o, 1);
        check("single_done_count", done_cyc.size(), 1);

        // Back-to-back via holding buffer
        done_cyc.delete();
        send_block(BLK_A);
        wait_idx(126);
        send_block(BLK_B);
        check("b2b_ready_low", blk_ready_o, 0);
        check("b2b_busy", busy_o, 1);
        check("b2b_idx_127", bit_idx_o, 127);
        @(posedge clk); #1;
        check("b2b_ready_rise", blk_ready_o, 1);
        check("b2b_next_valid", bit_valid_o, 1);
        check("b2b_next_idx", bit_idx_o, 0);
        wait_empty();
        check("b2b_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) check("b2b_done_spacing", done_cyc[1] - done_cyc[0], 128);

        // Sink stall: ready toggles each cycle
        bit_ready_i = 1'b0;
        send_block(BLK_C);
        n = 0;
        while (q.size() != 0 && n < 700) begin
            bit_ready_i = ~bit_ready_i;
            @(posedge clk); #1;
            n++;
        end
        check("stall_cycles", n, 255);
        bit_ready_i = 1'b1;
        @(posedge clk); #1;

        // Bypass on last bit
        done_cyc.delete();
        send_block(BLK_C);
        wait_idx(127);
        send_block(BLK_D);
        check("bypass_valid", bit_valid_o, 1);
        check("bypass_idx", bit_idx_o, 0);
        check("bypass_ready", blk_ready_o, 1);
        check("bypass_msb", bit_o, BLK_D[DW-1]);
        wait_empty();
        check("bypass_done_count", done_cyc.size(), 2);

        // Abort at bit 60 with buffer full
        send_block(BLK_E);
        wait_idx(59);
        send_block(BLK_F);
        check("abort_buf_full", blk_ready_o, 0);
        check("abort_at_idx", bit_idx_o, 60);
        done_cyc.delete();
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        q.delete();
        check("abort_valid", bit_valid_o, 0);
        check("abort_ready", blk_ready_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_bit_o", bit_o, 0);
        check("abort_idx", bit_idx_o, 0);
        send_block(BLK_G);
        wait_empty();
        check("abort_done_count", done_cyc.size(), 1);

        // Async reset mid-block
        send_block(BLK_B);
        wait_idx(90);
        done_cyc.delete();
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        check("arst_valid", bit_valid_o, 0);
        check("arst_ready", blk_ready_o, 1);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_bit_o", bit_o, 0);
        check("arst_idx", bit_idx_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("arst_no_done", done_cyc.size(), 0);
        send_block(BLK_E);
        wait_empty();
        check("arst_after_done", done_cyc.size(), 1);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
